// File: rtl/fir_decimator.sv
// Accumulate-and-dump decimator: averages each block of 2^LOG2_DEC accepted samples
// into one round-half-up output, with ready/valid backpressure on both sides.
module fir_decimator #(
  parameter int WW_INPUT  = 16,
  parameter int WW_OUTPUT = 16,
  parameter int LOG2_DEC  = 2
) (
  input  logic                 clk,
  input  logic                 i_arst,
  input  logic                 i_en,
  input  logic [WW_INPUT-1:0]  i_is_data,
  input  logic                 i_is_dv,
  output logic                 o_is_rfd,
  output logic [WW_OUTPUT-1:0] o_os_data,
  output logic                 o_os_dv,
  input  logic                 i_os_rfd
);

  localparam int AW = WW_INPUT + LOG2_DEC;
  // Extended width leaves headroom for the rounding add and a clean output slice.
  localparam int EW = WW_OUTPUT + LOG2_DEC + 1;
  localparam int PW = (LOG2_DEC > 0) ? LOG2_DEC : 1;
  localparam logic [PW-1:0] LAST = PW'((1 << LOG2_DEC) - 1);
  localparam logic [EW-1:0] RND  = EW'((1 << LOG2_DEC) >> 1);

  logic [AW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [WW_OUTPUT-1:0] data_q, data_d;
  logic                 dv_q, dv_d;

  logic          last_s;
  logic          in_xfer_s;
  logic          out_xfer_s;
  logic [EW-1:0] sum_s;
  logic [EW-1:0] rnd_s;
  logic [EW-1:0] shr_s;
  logic          unused_s;

  assign last_s     = (phase_q == LAST);
  // Stall only when this input would dump into an output that downstream has not taken.
  assign o_is_rfd   = i_en & ~i_arst & ~(last_s & dv_q & ~i_os_rfd);
  assign in_xfer_s  = i_is_dv & o_is_rfd;
  assign out_xfer_s = i_en & dv_q & i_os_rfd;

  assign sum_s    = {{(EW-AW){acc_q[AW-1]}}, acc_q}
                  + {{(EW-WW_INPUT){i_is_data[WW_INPUT-1]}}, i_is_data};
  assign rnd_s    = sum_s + RND;
  assign shr_s    = $signed(rnd_s) >>> LOG2_DEC;
  assign unused_s = ^shr_s[EW-1:WW_OUTPUT];

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    data_d  = data_q;
    if (out_xfer_s) begin
      dv_d = 1'b0;
    end else begin
      dv_d = dv_q;
    end
    if (in_xfer_s) begin
      if (last_s) begin
        acc_d   = '0;
        phase_d = '0;
        data_d  = shr_s[WW_OUTPUT-1:0];
        dv_d    = 1'b1;
      end else begin
        acc_d   = sum_s[AW-1:0];
        phase_d = phase_q + PW'(1);
      end
    end else begin
      acc_d   = acc_q;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      acc_q   <= '0;
      phase_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  assign o_os_data = data_q;
  assign o_os_dv   = dv_q;

endmodule
